fdiv_iter: RTL and testbench

- Multi-cycle single-precision floating-point divider, y = x1 / x2; the inverse-operation companion to the pipelined multiplier in the FPU.
- Computes the mantissa quotient by iterative restoring division, one quotient bit per cycle.
- Uses a valid/ready input handshake and a one-cycle out_valid result pulse, so the FPU dispatch logic can issue to it and collect from it like the other units.

---
 rtl/fdiv_iter_if.sv | 23 ++
 rtl/fdiv_iter.sv | 158 +++++++++++++++
 tb/tb_fdiv_iter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fdiv_iter_if.sv
// Handshake and operand/result bundle for the iterative binary32 divider.
// The master issues operands and collects results; the slave is the divider.
interface fdiv_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        ovf;
    logic        unf;
    logic        dz;
    logic        out_valid;

    modport master (
        output in_valid, x1, x2,
        input  in_ready, y, ovf, unf, dz, out_valid
    );

    modport slave (
        input  in_valid, x1, x2,
        output in_ready, y, ovf, unf, dz, out_valid
    );
endinterface

// File: rtl/fdiv_iter.sv
// Multi-cycle binary32 divider, y = x1 / x2, using restoring division
// (one quotient bit per cycle), round-half-up, and denormals flushed to zero.
module fdiv_iter (
    input  logic        sys_clk,
    input  logic        rst,
    fdiv_iter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM
    } state_t;

    state_t             state;
    logic               sgn;
    logic               z1;
    logic               z2;
    logic signed [9:0]  e_pre;
    logic [23:0]        m2;
    logic [25:0]        rem;
    logic [25:0]        q;
    logic [4:0]         cnt;

    logic               in_ready_r;
    logic [31:0]        y_r;
    logic               ovf_r;
    logic               unf_r;
    logic               dz_r;
    logic               out_valid_r;

    assign bus.in_ready  = in_ready_r;
    assign bus.y         = y_r;
    assign bus.ovf       = ovf_r;
    assign bus.unf       = unf_r;
    assign bus.dz        = dz_r;
    assign bus.out_valid = out_valid_r;

    // Operand decode at the accept edge
    logic [7:0]         e1_in;
    logic [7:0]         e2_in;
    logic signed [9:0]  e_pre_in;

    assign e1_in    = bus.x1[30:23];
    assign e2_in    = bus.x2[30:23];
    assign e_pre_in = $signed({2'b00, e1_in}) - $signed({2'b00, e2_in}) + 10'sd127;

    // One restoring-division step; remainder stays below 2*m2 < 2^25
    logic [25:0]        diff;
    logic               ge;

    assign ge   = (rem >= {2'b00, m2});
    assign diff = rem - {2'b00, m2};

    // Normalize, round and select the packed result
    logic [23:0]        frac_r;
    logic signed [9:0]  exp_n;
    logic [31:0]        y_n;
    logic               ovf_n;
    logic               unf_n;
    logic               dz_n;

    always_comb begin
        frac_r = '0;
        exp_n  = '0;
        y_n    = '0;
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        dz_n   = 1'b0;

        if (q[25]) begin
            frac_r = {1'b0, q[24:2]} + {23'b0, q[1]};
            exp_n  = e_pre;
        end else begin
            frac_r = {1'b0, q[23:1]} + {23'b0, q[0]};
            exp_n  = e_pre - 10'sd1;
        end
        if (frac_r[23]) begin
            frac_r = '0;
            exp_n  = exp_n + 10'sd1;
        end

        if (z2 && z1) begin
            y_n  = 32'h7FC0_0000;
            dz_n = 1'b1;
        end else if (z2) begin
            y_n  = {sgn, 8'hFF, 23'b0};
            dz_n = 1'b1;
        end else if (z1) begin
            y_n  = {sgn, 31'b0};
        end else if (exp_n >= 10'sd255) begin
            y_n   = {sgn, 8'hFF, 23'b0};
            ovf_n = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            y_n   = {sgn, 31'b0};
            unf_n = 1'b1;
        end else begin
            y_n = {sgn, exp_n[7:0], frac_r[22:0]};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            sgn         <= 1'b0;
            z1          <= 1'b0;
            z2          <= 1'b0;
            e_pre       <= '0;
            m2          <= '0;
            rem         <= '0;
            q           <= '0;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            y_r         <= '0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            dz_r        <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sgn        <= bus.x1[31] ^ bus.x2[31];
                        z1         <= (e1_in == 8'd0);
                        z2         <= (e2_in == 8'd0);
                        e_pre      <= e_pre_in;
                        rem        <= {2'b01, bus.x1[22:0]};
                        m2         <= {1'b1, bus.x2[22:0]};
                        q          <= '0;
                        cnt        <= 5'd26;
                        in_ready_r <= 1'b0;
                        state      <= DIV;
                    end
                end
                DIV: begin
                    q   <= {q[24:0], ge};
                    rem <= ge ? {diff[24:0], 1'b0} : {rem[24:0], 1'b0};
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    y_r         <= y_n;
                    ovf_r       <= ovf_n;
                    unf_r       <= unf_n;
                    dz_r        <= dz_n;
                    out_valid_r <= 1'b1;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: latency, rounding, special cases, exponent
// boundaries, back-to-back issue and mid-operation reset.
module tb_fdiv_iter;
    logic sys_clk = 1'b0;
    logic rst;

    always #5 sys_clk = ~sys_clk;

    fdiv_iter_if bus ();

    fdiv_iter dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for out_valid after an accept edge; counts edges and busy-time in_ready highs
    task automatic wait_result(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy++;
            @(posedge sys_clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ey, input logic [2:0] eflags);
        int lat;
        int busy;
        @(negedge sys_clk);
        check({tag, "_ready"}, {31'b0, bus.in_ready}, 32'd1);
        bus.x1       = a;
        bus.x2       = b;
        bus.in_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x1       = 32'hFFFF_FFFF;
        bus.x2       = 32'h1234_5678;
        wait_result(lat, busy);
        check({tag, "_lat"}, lat, 32'd27);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_y"}, bus.y, ey);
        check({tag, "_flags"}, {29'b0, bus.ovf, bus.unf, bus.dz}, {29'b0, eflags});
        @(posedge sys_clk);
        #1;
        check({tag, "_pulse"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "_hold"}, bus.y, ey);
    endtask

    initial begin
        int lat;
        int busy;
        int pulses;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.x1       = '0;
        bus.x2       = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_ovalid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_y", bus.y, 32'd0);
        check("rst_flags", {29'b0, bus.ovf, bus.unf, bus.dz}, 32'd0);
        rst = 1'b0;

        // value, rounding, specials, exponent boundaries (flags = {ovf,unf,dz})
        run_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);
        run_op("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 3'b000);
        run_op("one_div_one", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000);
        run_op("neg_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 3'b001);
        run_op("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001);
        run_op("denorm_divisor", 32'h3F80_0000, 32'h0040_0000, 32'h7F80_0000, 3'b001);
        run_op("neg_zero_num", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3'b000);
        run_op("denorm_num", 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000);
        run_op("ovf_256", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 3'b100);
        run_op("ovf_255", 32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 3'b100);
        run_op("unf_0", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 3'b010);
        run_op("exp_1_ok", 32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 3'b000);
        run_op("unf_norm_shift", 32'h0080_0000, 32'h3FC0_0000, 32'h0000_0000, 3'b010);

        // back-to-back: second request held from the cycle after the first accept
        @(negedge sys_clk);
        bus.x1       = 32'h40C0_0000;
        bus.x2       = 32'h4000_0000;
        bus.in_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.x1 = 32'hC0C0_0000;
        bus.x2 = 32'h4000_0000;
        wait_result(lat, busy);
        check("b2b_a_lat", lat, 32'd27);
        check("b2b_a_busy", busy, 32'd0);
        check("b2b_a_y", bus.y, 32'h4040_0000);
        check("b2b_a_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge sys_clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(lat, busy);
        check("b2b_b_gap", lat + 1, 32'd28);
        check("b2b_b_y", bus.y, 32'hC040_0000);
        check("b2b_b_flags", {29'b0, bus.ovf, bus.unf, bus.dz}, 32'd0);

        // reset mid-operation abandons the result
        @(negedge sys_clk);
        bus.x1       = 32'h40C0_0000;
        bus.x2       = 32'h4000_0000;
        bus.in_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge sys_clk);
        #1;
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        check("mid_rst_ready", {31'b0, bus.in_ready}, 32'd1);
        check("mid_rst_ovalid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_y", bus.y, 32'd0);
        check("mid_rst_flags", {29'b0, bus.ovf, bus.unf, bus.dz}, 32'd0);
        pulses = 0;
        repeat (35) begin
            @(posedge sys_clk);
            #1;
            if (bus.out_valid) pulses++;
        end
        check("mid_rst_no_pulse", pulses, 32'd0);
        run_op("after_rst", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
